// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO.
//   FIFO_MODE_STD  : registered read, read_valid pulses once per accepted read
//   FIFO_MODE_FWFT : head word shown combinationally, read_en pops it
//   clog2()        : ceiling log2, used for count and pointer widths
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_flags.
// One synchronous write port and one asynchronous (combinational) read port.
// WIDTH is left free so the top level can add a parity bit to each word.
// Ports:
//   clk        : write clock, rising edge
//   write_en   : store write_data at write_addr on this edge
//   write_addr : write location, always < DEPTH
//   write_data : word to store
//   read_addr  : read location, always < DEPTH
//   read_data  : mem[read_addr], combinational
module sync_fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [WIDTH-1:0]  read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are not reset; they are don't-care until written.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy count and status flags.
// Any DEPTH >= 2 is supported; pointers wrap explicitly at DEPTH-1.
// Build option: define SYNC_FIFO_PARITY_EN to store an even-parity bit with
// each word and report mismatches on parity_err (otherwise parity_err = 0).
// Ports:
//   clk, reset_n      : clock (rising edge) and asynchronous active-low reset
//   flush             : synchronous clear of contents and error flags
//   write_en/_data    : push request and word
//   read_en           : pop request
//   read_data/_valid  : output word and its qualifier (mode dependent)
//   full, empty, almost_full, almost_empty, count : occupancy status
//   overflow/underflow: sticky rejected-write / rejected-read flags
//   parity_err        : parity mismatch on the word being read
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = FIFO_MODE_STD,
    localparam int CNT_W        = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  parity_err
);

    localparam int PTR_W = clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] CNT_AEMPTY = CNT_W'(AEMPTY_THRESH);

`ifdef SYNC_FIFO_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             empty_q;
    logic             full_q;
    logic             afull_q;
    logic             aempty_q;
    logic             ovf_q;
    logic             unf_q;
    logic             wr_accept;
    logic             rd_accept;
    logic [MEM_W-1:0] ram_wdata;
    logic [MEM_W-1:0] ram_q;
    logic             ram_perr;

`ifdef SYNC_FIFO_PARITY_EN
    // Even parity: stored word including the parity bit XORs to zero.
    assign ram_wdata = {^write_data, write_data};
    assign ram_perr  = ^ram_q;
`else
    assign ram_wdata = write_data;
    assign ram_perr  = 1'b0;
`endif

    // Request qualification and next occupancy. Flush drops both requests.
    always_comb begin
        wr_accept = write_en && !full_q && !flush;
        rd_accept = read_en && !empty_q && !flush;
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_accept && !rd_accept) begin
            count_nxt = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_nxt = count_q - 1'b1;
        end
    end

    // Pointers, count and flags; flags derive from count_nxt so they line
    // up with count in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            empty_q  <= (count_nxt == '0);
            full_q   <= (count_nxt == CNT_FULL);
            afull_q  <= (count_nxt >= CNT_AFULL);
            aempty_q <= (count_nxt <= CNT_AEMPTY);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end else begin
                if (wr_accept) begin
                    wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                end
                if (rd_accept) begin
                    rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
                end
                if (write_en && full_q) begin
                    ovf_q <= 1'b1;
                end
                if (read_en && empty_q) begin
                    unf_q <= 1'b1;
                end
            end
        end
    end

    sync_fifo_ram #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk        (clk),
        .write_en   (wr_accept),
        .write_addr (wr_ptr),
        .write_data (ram_wdata),
        .read_addr  (rd_ptr),
        .read_data  (ram_q)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is always presented; read_en only pops it.
            assign read_data  = ram_q[DATA_WIDTH-1:0];
            assign read_valid = !empty_q;
            assign parity_err = !empty_q && ram_perr;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_p1;
            logic                  vld_p1;
            logic                  perr_p1;

            // Output register stage: data held between accepted reads.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_data_p1 <= '0;
                    vld_p1     <= 1'b0;
                    perr_p1    <= 1'b0;
                end else begin
                    vld_p1  <= rd_accept;
                    perr_p1 <= rd_accept && ram_perr;
                    if (rd_accept) begin
                        rd_data_p1 <= ram_q[DATA_WIDTH-1:0];
                    end
                end
            end

            assign read_data  = rd_data_p1;
            assign read_valid = vld_p1;
            assign parity_err = perr_p1;
        end
    endgenerate

    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
